// File: rtl/chip_host_link_pkg.sv
// Shared types and accelerator geometry for the host link: FSM states,
// result record layout and the default bus/feature-map sizes.
package chip_host_link_pkg;

    localparam int IO_BUS_W     = 48;
    localparam int IO_DATA_W    = 16;
    localparam int FM_WIDTH     = 130;
    localparam int FM_HEIGHT    = 130;
    localparam int OUT_CHANNELS = 16;
    localparam int RES_DEPTH    = 4;

    localparam int X_W  = $clog2(FM_WIDTH);
    localparam int Y_W  = $clog2(FM_HEIGHT);
    localparam int CH_W = $clog2(OUT_CHANNELS);

    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER,
        DRAIN
    } state_e;

    // Result record as seen on res_data, most significant field first.
    typedef struct packed {
        logic [CH_W-1:0]      ch;
        logic [Y_W-1:0]       y;
        logic [X_W-1:0]       x;
        logic [IO_DATA_W-1:0] word;
    } res_rec_t;

endpackage

// File: rtl/chip_host_link_result_fifo.sv
// Small result buffer between the accelerator strobe and the result sink.
// A push while full is accepted only when the head leaves in the same cycle.
module result_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         arst_n_in,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_q, rd_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/chip_host_link.sv
// Host-side link to the accelerator: job FSM, kernel/data arbitration onto
// the shared tri-state bus, and result capture into a small FIFO.
module chip_host_link
    import chip_host_link_pkg::*;
#(
    parameter int IO_BUS_WIDTH       = IO_BUS_W,
    parameter int IO_DATA_WIDTH      = IO_DATA_W,
    parameter int FEATURE_MAP_WIDTH  = FM_WIDTH,
    parameter int FEATURE_MAP_HEIGHT = FM_HEIGHT,
    parameter int OUTPUT_NB_CHANNELS = OUT_CHANNELS,
    localparam int XW    = $clog2(FEATURE_MAP_WIDTH),
    localparam int YW    = $clog2(FEATURE_MAP_HEIGHT),
    localparam int CHW   = $clog2(OUTPUT_NB_CHANNELS),
    localparam int RES_W = IO_DATA_WIDTH + XW + YW + CHW
) (
    input  logic                    clk,
    input  logic                    arst_n_in,
    input  logic                    run_req,
    output logic                    busy,
    input  logic                    krn_valid,
    output logic                    krn_ready,
    input  logic [IO_BUS_WIDTH-1:0] krn_data,
    input  logic                    dat_valid,
    output logic                    dat_ready,
    input  logic [IO_BUS_WIDTH-1:0] dat_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [RES_W-1:0]        res_data,
    inout  wire  [IO_BUS_WIDTH-1:0] io_bus,
    output logic                    a_valid,
    input  logic                    a_ready,
    output logic                    b_valid,
    input  logic                    b_ready,
    input  logic                    output_valid,
    input  logic [XW-1:0]           output_x,
    input  logic [YW-1:0]           output_y,
    input  logic [CHW-1:0]          output_ch,
    output logic                    start,
    input  logic                    done,
    output logic [31:0]             result_count,
    output logic                    overflow
);

    state_e                  state_q, state_d;
    logic [IO_BUS_WIDTH-1:0] hold_q;
    logic                    a_valid_q, b_valid_q, done_seen_q, overflow_q;
    logic [31:0]             count_q;
    logic                    held, hs, done_any, can_launch, launch_k, launch_d, job_start;
    logic                    fifo_full, fifo_empty, fifo_pop;

    assign held     = a_valid_q | b_valid_q;
    assign hs       = (a_valid_q & a_ready) | (b_valid_q & b_ready);
    assign done_any = done | done_seen_q;

    // A slot frees up on the handshake edge itself, so a new word can follow
    // without a bubble. Launching stops once done is seen or a result is on the bus.
    assign can_launch = (state_q == XFER) && (!held || hs) && !output_valid && !done_any;
    assign launch_k   = can_launch && krn_valid && b_ready;
    assign launch_d   = can_launch && !launch_k && dat_valid && a_ready;

    always_comb begin
        state_d   = state_q;
        job_start = 1'b0;
        unique case (state_q)
            IDLE:  if (run_req) begin
                       state_d   = START;
                       job_start = 1'b1;
                   end
            START: state_d = XFER;
            XFER:  if (done_any && (!held || hs)) state_d = DRAIN;
            DRAIN: if (fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q     <= IDLE;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            // done may be a single-cycle pulse; remember it while a word drains
            done_seen_q <= (state_q == XFER) && (state_d == XFER) && done_any;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            hold_q    <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else if (launch_k || launch_d) begin
            hold_q    <= launch_k ? krn_data : dat_data;
            b_valid_q <= launch_k;
            a_valid_q <= launch_d;
        end else if (hs) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (job_start) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (output_valid) count_q <= count_q + 32'd1;
            if (output_valid && fifo_full && !fifo_pop) overflow_q <= 1'b1;
        end
    end

    assign io_bus = held ? hold_q : {IO_BUS_WIDTH{1'bz}};

    assign fifo_pop = !fifo_empty && res_ready;

    result_fifo #(
        .W     (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .push      (output_valid),
        .din       ({output_ch, output_y, output_x, io_bus[IO_DATA_WIDTH-1:0]}),
        .pop       (fifo_pop),
        .dout      (res_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign start        = (state_q == START);
    assign busy         = (state_q != IDLE);
    assign krn_ready    = launch_k;
    assign dat_ready    = launch_d;
    assign a_valid      = a_valid_q;
    assign b_valid      = b_valid_q;
    assign res_valid    = !fifo_empty;
    assign result_count = count_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_chip_host_link.sv
// Bench for chip_host_link: table-driven result-buffer vectors, hand-written
// handshake/reset sequences, and a randomized phase against a queue model.
module tb_chip_host_link;
    import chip_host_link_pkg::*;

    localparam int RW = $bits(res_rec_t);

    logic              clk = 1'b0;
    logic              arst_n_in, run_req, busy;
    logic              krn_valid, krn_ready, dat_valid, dat_ready;
    logic [47:0]       krn_data, dat_data;
    logic              res_valid, res_ready;
    logic [RW-1:0]     res_data;
    wire  [47:0]       io_bus;
    logic              a_valid, a_ready, b_valid, b_ready;
    logic              output_valid, start, done, overflow;
    logic [X_W-1:0]    output_x;
    logic [Y_W-1:0]    output_y;
    logic [CH_W-1:0]   output_ch;
    logic [31:0]       result_count;

    logic              drv_en = 1'b0;
    logic [47:0]       drv_val = '0;
    assign io_bus = drv_en ? drv_val : 48'bz;

    int checks = 0, failures = 0, ab_viol = 0;

    logic [47:0]   exp_k[$], exp_d[$];
    logic [RW-1:0] mq[$];
    int unsigned   m_cnt;
    logic          m_ovf;

    always #5 clk = ~clk;

    always @(negedge clk) if (a_valid && b_valid) ab_viol++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    chip_host_link dut (
        .clk(clk), .arst_n_in(arst_n_in), .run_req(run_req), .busy(busy),
        .krn_valid(krn_valid), .krn_ready(krn_ready), .krn_data(krn_data),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .io_bus(io_bus), .a_valid(a_valid), .a_ready(a_ready),
        .b_valid(b_valid), .b_ready(b_ready), .output_valid(output_valid),
        .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
        .start(start), .done(done), .result_count(result_count), .overflow(overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The DUT must not be driving: a foreign value has to read back intact.
    task automatic chk_bus_z(input string name);
        drv_val = 48'hC3A5_5A3C_0F0F;
        drv_en  = 1'b1;
        #1;
        chk(name, io_bus, 48'hC3A5_5A3C_0F0F);
        drv_en  = 1'b0;
    endtask

    function automatic logic [RW-1:0] mkrec(input logic [15:0] w);
        res_rec_t r;
        r.word = w;
        r.x    = X_W'(w * 16'd3);
        r.y    = Y_W'(w + 16'd10);
        r.ch   = CH_W'(w);
        return r;
    endfunction

    task automatic set_out(input logic ov, input res_rec_t r);
        output_valid = ov;
        output_x     = r.x;
        output_y     = r.y;
        output_ch    = r.ch;
        drv_val      = {32'hDEAD_BEEF, r.word};
        drv_en       = ov;
    endtask

    // One randomized cycle; the model sees the pre-edge values and is updated
    // as if the edge had happened.
    task automatic rstep(input bit fin);
        res_rec_t r;
        bit kf, df;
        r = RW'({$urandom, $urandom});
        if (!fin) begin
            if (!krn_valid && $urandom_range(0, 2) == 0) begin
                krn_valid = 1'b1;
                krn_data  = 48'({$urandom, $urandom});
            end
            if (!dat_valid && $urandom_range(0, 2) == 0) begin
                dat_valid = 1'b1;
                dat_data  = 48'({$urandom, $urandom});
            end
            a_ready   = 1'($urandom_range(0, 1));
            b_ready   = 1'($urandom_range(0, 1));
            res_ready = 1'($urandom_range(0, 1));
            if (!a_valid && !b_valid && $urandom_range(0, 1) == 0) set_out(1'b1, r);
            else set_out(1'b0, r);
        end else begin
            a_ready = 1'b1; b_ready = 1'b1; res_ready = 1'b1;
            set_out(1'b0, r);
        end
        #1;
        if (b_valid && b_ready) begin
            chk("rnd_k_in_flight", 64'(exp_k.size()), 64'd1);
            if (exp_k.size() != 0) chk("rnd_k_word", io_bus, exp_k.pop_front());
        end
        if (a_valid && a_ready) begin
            chk("rnd_d_in_flight", 64'(exp_d.size()), 64'd1);
            if (exp_d.size() != 0) chk("rnd_d_word", io_bus, exp_d.pop_front());
        end
        kf = krn_valid && krn_ready;
        df = dat_valid && dat_ready;
        if (kf) exp_k.push_back(krn_data);
        if (df) exp_d.push_back(dat_data);
        chk("rnd_res_valid", res_valid, mq.size() != 0);
        if (mq.size() != 0 && res_ready) chk("rnd_res_data", res_data, mq.pop_front());
        if (output_valid) begin
            m_cnt++;
            if (mq.size() < RES_DEPTH) mq.push_back(r);
            else m_ovf = 1'b1;
        end
        tick();
        if (kf) krn_valid = 1'b0;
        if (df) dat_valid = 1'b0;
    endtask

    typedef struct {
        logic        ov;
        logic [15:0] word;
        logic        rdy;
        logic        exp_rv;
        logic [15:0] exp_head;
        logic [31:0] exp_cnt;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 16'd1, 1'b0, 1'b1, 16'd1, 32'd1, 1'b0};
        tbl[1]  = '{1'b1, 16'd2, 1'b0, 1'b1, 16'd1, 32'd2, 1'b0};
        tbl[2]  = '{1'b1, 16'd3, 1'b0, 1'b1, 16'd1, 32'd3, 1'b0};
        tbl[3]  = '{1'b1, 16'd4, 1'b0, 1'b1, 16'd1, 32'd4, 1'b0};
        tbl[4]  = '{1'b1, 16'd5, 1'b0, 1'b1, 16'd1, 32'd5, 1'b1};
        tbl[5]  = '{1'b1, 16'd6, 1'b0, 1'b1, 16'd1, 32'd6, 1'b1};
        tbl[6]  = '{1'b1, 16'd7, 1'b1, 1'b1, 16'd2, 32'd7, 1'b1};
        tbl[7]  = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd3, 32'd7, 1'b1};
        tbl[8]  = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd4, 32'd7, 1'b1};
        tbl[9]  = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd7, 32'd7, 1'b1};
        tbl[10] = '{1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 32'd7, 1'b1};

        arst_n_in = 1'b0; run_req = 1'b0; done = 1'b0;
        krn_valid = 1'b0; krn_data = '0; dat_valid = 1'b0; dat_data = '0;
        a_ready = 1'b0; b_ready = 1'b0; res_ready = 1'b0;
        set_out(1'b0, '0);

        // Reset state
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_start", start, 0);
        chk("rst_ab_valid", {a_valid, b_valid}, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", result_count, 0);
        chk_bus_z("rst_bus_z");
        @(negedge clk) arst_n_in = 1'b1;
        tick();

        // Job start
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("setup_start_hi", start, 1);
        chk("setup_busy_hi", busy, 1);
        tick();
        chk("setup_start_lo", start, 0);
        chk("setup_busy_xfer", busy, 1);

        // Kernel word held while b_ready is low
        krn_data = 48'h0003_0002_0001; krn_valid = 1'b1; b_ready = 1'b1;
        #1 chk("k_launch_ready", krn_ready, 1);
        tick();
        krn_valid = 1'b0; b_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("k_hold_valid%0d", i), b_valid, 1);
            chk($sformatf("k_hold_bus%0d", i), io_bus, 48'h0003_0002_0001);
            tick();
        end
        b_ready = 1'b1;
        #1 chk("k_valid_at_hs", b_valid, 1);
        tick();
        chk("k_valid_drop", b_valid, 0);
        chk_bus_z("k_bus_z");
        b_ready = 1'b0;

        // Kernel wins over data, then data follows back to back
        krn_data = 48'h1111_2222_3333; dat_data = 48'h4444_5555_6666;
        krn_valid = 1'b1; dat_valid = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
        #1;
        chk("arb_krn_ready", krn_ready, 1);
        chk("arb_dat_ready_lo", dat_ready, 0);
        tick();
        krn_valid = 1'b0;
        #1;
        chk("arb_b_first", {a_valid, b_valid}, 2'b01);
        chk("arb_bus_k", io_bus, 48'h1111_2222_3333);
        chk("arb_dat_ready", dat_ready, 1);
        tick();
        dat_valid = 1'b0;
        chk("arb_a_second", {a_valid, b_valid}, 2'b10);
        chk("arb_bus_d", io_bus, 48'h4444_5555_6666);
        tick();
        chk("arb_a_drop", a_valid, 0);
        a_ready = 1'b0; b_ready = 1'b0;

        // Result buffer fill, overflow, full push+pop, drain
        for (int i = 0; i < 11; i++) begin
            set_out(tbl[i].ov, mkrec(tbl[i].word));
            res_ready = tbl[i].rdy;
            tick();
            chk($sformatf("tbl%0d_res_valid", i), res_valid, tbl[i].exp_rv);
            if (tbl[i].exp_rv) chk($sformatf("tbl%0d_res_data", i), res_data, mkrec(tbl[i].exp_head));
            chk($sformatf("tbl%0d_count", i), result_count, tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_overflow", i), overflow, tbl[i].exp_ovf);
        end
        set_out(1'b0, '0);
        res_ready = 1'b0;

        // done while a_valid is held; DRAIN waits for the buffered result
        set_out(1'b1, mkrec(16'h0055));
        tick();
        set_out(1'b0, '0);
        dat_data = 48'hAAAA_BBBB_CCCC; dat_valid = 1'b1; a_ready = 1'b1;
        #1 chk("dn_dat_ready", dat_ready, 1);
        tick();
        dat_valid = 1'b0; a_ready = 1'b0; done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dn_hold_valid%0d", i), a_valid, 1);
            chk($sformatf("dn_hold_bus%0d", i), io_bus, 48'hAAAA_BBBB_CCCC);
            tick();
            done = 1'b0;
        end
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        chk("dn_a_drop", a_valid, 0);
        chk("dn_busy_drain", busy, 1);
        chk("dn_res_pending", res_valid, 1);
        tick();
        chk("dn_still_drain", busy, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("dn_popped", res_valid, 0);
        chk("dn_busy_last", busy, 1);
        tick();
        chk("dn_idle", busy, 0);

        // Randomized job against the queue model
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("job2_count_clr", result_count, 0);
        chk("job2_ovf_clr", overflow, 0);
        tick();
        m_cnt = 0; m_ovf = 1'b0;
        for (int c = 0; c < 600; c++) rstep(1'b0);
        begin
            int n = 0;
            while ((krn_valid || dat_valid || a_valid || b_valid) && n < 50) begin
                rstep(1'b1);
                n++;
            end
            chk("rnd_quiesce_timeout", n < 50, 1);
        end
        done = 1'b1;
        rstep(1'b1);
        done = 1'b0;
        begin
            int n = 0;
            while (busy && n < 50) begin
                rstep(1'b1);
                n++;
            end
            chk("rnd_idle", busy, 0);
        end
        chk("rnd_count", result_count, 64'(m_cnt));
        chk("rnd_overflow", overflow, m_ovf);
        chk("rnd_model_empty", 64'(mq.size() + exp_k.size() + exp_d.size()), 0);

        // Reset in the middle of a transfer
        run_req = 1'b1; tick(); run_req = 1'b0; tick();
        krn_data = 48'h0BAD_0BAD_0BAD; krn_valid = 1'b1; b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        set_out(1'b1, mkrec(16'h0077));
        tick();
        set_out(1'b0, '0);
        chk("mid_b_valid", b_valid, 1);
        #2 arst_n_in = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_start", start, 0);
        chk("ar_ab_valid", {a_valid, b_valid}, 0);
        chk("ar_readies", {krn_ready, dat_ready}, 0);
        chk("ar_res_valid", res_valid, 0);
        chk("ar_overflow", overflow, 0);
        chk("ar_count", result_count, 0);
        chk_bus_z("ar_bus_z");
        krn_valid = 1'b0;
        @(negedge clk);
        @(negedge clk) begin
            arst_n_in = 1'b1;
            a_ready   = 1'b1;
            b_ready   = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_quiet%0d", i), {a_valid, b_valid, res_valid, busy}, 0);
        end

        chk("ab_exclusive", ab_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
